// File: rtl/regfile_seq_pkg.sv
// Shared widths, command opcodes and sequencer states for the regfile sequencer.
package regfile_seq_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_COPY = 2'b01,
        OP_SWAP = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
        RESP = 3'd5
    } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Command-driven master for an external register file: turns LOAD/COPY/SWAP/READ
// commands into one-cycle-per-state read and write cycles on the regfile ports.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RD_A  | read src into tmp_a
// RD_B  | read dst into tmp_b (SWAP only)
// WR_A  | write tmp_b to src (SWAP only)
// WR_B  | write imm (LOAD) or tmp_a to dst
// RESP  | present READ result
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = regfile_seq_pkg::DATA_W,
    parameter int ADDR_W = regfile_seq_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              done
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] tmp_a_q, tmp_a_d;
    logic [DATA_W-1:0] tmp_b_q, tmp_b_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    assign cmd_ready = (state_q == IDLE) && rst_n;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dst_d      = dst_q;
        src_d      = src_q;
        imm_d      = imm_q;
        tmp_a_d    = tmp_a_q;
        tmp_b_d    = tmp_b_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    dst_d   = cmd_dst;
                    src_d   = cmd_src;
                    imm_d   = cmd_imm;
                    state_d = (op_e'(cmd_op) == OP_LOAD) ? WR_B : RD_A;
                end
            end
            RD_A: begin
                tmp_a_d = r_data;
                // rsp_data is loaded alongside tmp_a so it equals tmp_a during RESP
                // and then holds until the next READ.
                if (op_q == OP_READ) begin
                    rsp_data_d = r_data;
                end
                case (op_q)
                    OP_SWAP: state_d = RD_B;
                    OP_READ: state_d = RESP;
                    default: state_d = WR_B;
                endcase
            end
            RD_B: begin
                tmp_b_d = r_data;
                state_d = WR_A;
            end
            WR_A:    state_d = WR_B;
            WR_B:    state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_LOAD;
            dst_q      <= '0;
            src_q      <= '0;
            imm_q      <= '0;
            tmp_a_q    <= '0;
            tmp_b_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            imm_q      <= imm_d;
            tmp_a_q    <= tmp_a_d;
            tmp_b_q    <= tmp_b_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Port drive is a pure decode of state_q, so an async reset clears it at once.
    always_comb begin
        r_addr    = '0;
        w_addr    = '0;
        w_data    = '0;
        w_en      = 1'b0;
        rsp_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            RD_A: r_addr = src_q;
            RD_B: r_addr = dst_q;
            WR_A: begin
                w_en   = 1'b1;
                w_addr = src_q;
                w_data = tmp_b_q;
            end
            WR_B: begin
                w_en   = 1'b1;
                w_addr = dst_q;
                w_data = (op_q == OP_LOAD) ? imm_q : tmp_a_q;
                done   = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural 8x16 regfile, directed table, busy/abort
// sequences and random commands checked against an array-based model.
module tb_regfile_sequencer;
    import regfile_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src;
    logic [15:0] cmd_imm;
    logic [15:0] w_data;
    logic [2:0]  w_addr;
    logic        w_en;
    logic [2:0]  r_addr;
    logic [15:0] r_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        done;

    always #5 clk = ~clk;

    regfile_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
        .w_data(w_data), .w_addr(w_addr), .w_en(w_en),
        .r_addr(r_addr), .r_data(r_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done)
    );

    // External register file; keeps its contents through sequencer reset.
    logic [15:0] rf_mem [8];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'h0;
        end else if (w_en) begin
            rf_mem[w_addr] <= w_data;
        end
    end
    assign r_data = rf_mem[r_addr];

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] model [8];
    logic [15:0] last_rsp;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [15:0] imm;
        logic [15:0] exp_rsp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_R%0d", tag, i), rf_mem[i], model[i]);
        end
    endtask

    // Entered and left at a negedge; the leaving negedge is the cycle after done.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                          input logic [15:0] imm, output logic [15:0] rsp_out);
        int          waits = 0;
        int          lat = 0;
        int          nw = 0;
        int          wseen = 0;
        int          exp_lat = 0;
        bit          got_done = 1'b0;
        logic [2:0]  wa [2];
        logic [15:0] wd [2];
        logic [15:0] exp_rsp = 16'h0;
        logic [15:0] t;
        rsp_out = 16'h0;
        while (!cmd_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("ready_wait", (waits < 20), 1);
        case (op)
            2'b00: begin nw = 1; wa[0] = dst; wd[0] = imm; exp_lat = 1; end
            2'b01: begin nw = 1; wa[0] = dst; wd[0] = model[src]; exp_lat = 2; end
            2'b10: begin
                nw = 2; exp_lat = 4;
                wa[0] = src; wd[0] = model[dst];
                wa[1] = dst; wd[1] = model[src];
            end
            default: begin nw = 0; exp_lat = 2; exp_rsp = model[src]; end
        endcase
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
        @(posedge clk);
        while (!got_done && lat < 10) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
            if (w_en) begin
                if (wseen < nw) begin
                    check("w_addr", w_addr, wa[wseen]);
                    check("w_data", w_data, wd[wseen]);
                end
                wseen++;
            end
            check("rsp_valid", rsp_valid, (done && op == 2'b11));
            if (rsp_valid) begin
                check("rsp_data", rsp_data, exp_rsp);
                rsp_out = rsp_data;
            end
            if (done) got_done = 1'b1;
        end
        check("latency", lat, exp_lat);
        check("w_en_count", wseen, nw);
        case (op)
            2'b00: model[dst] = imm;
            2'b01: model[dst] = model[src];
            2'b10: begin t = model[src]; model[src] = model[dst]; model[dst] = t; end
            default: last_rsp = exp_rsp;
        endcase
        @(negedge clk);
        check("ready_after", cmd_ready, 1);
        check("rsp_hold", rsp_data, last_rsp);
        check_regs("regs");
    endtask

    vec_t        tbl [15];
    logic [15:0] r;

    initial begin
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dst = 3'd0; cmd_src = 3'd0; cmd_imm = 16'h0;
        mem_clr = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 16'h0;
        last_rsp = 16'h0;

        repeat (2) @(negedge clk);
        check("rst_w_en", w_en, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_done", done, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_r_addr", r_addr, 0);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_ready", cmd_ready, 1);

        tbl[0]  = '{2'b00, 3'd1, 3'd0, 16'h8000, 16'h0};
        tbl[1]  = '{2'b11, 3'd0, 3'd1, 16'h0,    16'h8000};
        tbl[2]  = '{2'b00, 3'd2, 3'd0, 16'h1000, 16'h0};
        tbl[3]  = '{2'b01, 3'd5, 3'd2, 16'h0,    16'h0};
        tbl[4]  = '{2'b11, 3'd0, 3'd5, 16'h0,    16'h1000};
        tbl[5]  = '{2'b11, 3'd0, 3'd2, 16'h0,    16'h1000};
        tbl[6]  = '{2'b00, 3'd3, 3'd0, 16'h00AA, 16'h0};
        tbl[7]  = '{2'b00, 3'd4, 3'd0, 16'h5500, 16'h0};
        tbl[8]  = '{2'b10, 3'd4, 3'd3, 16'h0,    16'h0};
        tbl[9]  = '{2'b11, 3'd0, 3'd3, 16'h0,    16'h5500};
        tbl[10] = '{2'b11, 3'd0, 3'd4, 16'h0,    16'h00AA};
        tbl[11] = '{2'b00, 3'd0, 3'd0, 16'h0001, 16'h0};
        tbl[12] = '{2'b00, 3'd7, 3'd0, 16'h0002, 16'h0};
        tbl[13] = '{2'b01, 3'd5, 3'd5, 16'h0,    16'h0};
        tbl[14] = '{2'b10, 3'd5, 3'd5, 16'h0,    16'h0};
        for (int i = 0; i < 15; i++) begin
            do_cmd(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].imm, r);
            if (tbl[i].op == 2'b11) check($sformatf("tbl%0d_rsp", i), r, tbl[i].exp_rsp);
        end
        do_cmd(2'b11, 3'd0, 3'd5, 16'h0, r);
        check("self_swap_R5", r, 16'h1000);

        // Command held on the bus during a SWAP must wait for IDLE.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dst = 3'd4; cmd_src = 3'd3; cmd_imm = 16'h0;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cmd_op = 2'b00; cmd_dst = 3'd6; cmd_imm = 16'hBEEF;
            check($sformatf("busy_ready_%0d", k), cmd_ready, 0);
            check($sformatf("busy_done_%0d", k), done, (k == 4));
        end
        r = model[3]; model[3] = model[4]; model[4] = r;
        @(negedge clk);
        check("busy_idle_ready", cmd_ready, 1);
        check("busy_no_early_load", rf_mem[6], model[6]);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_w_en", w_en, 1);
        check("held_w_addr", w_addr, 6);
        check("held_w_data", w_data, 16'hBEEF);
        check("held_done", done, 1);
        model[6] = 16'hBEEF;
        @(negedge clk);
        check_regs("held_regs");

        for (int n = 0; n < 300; n++) begin
            do_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   16'($urandom), r);
        end

        // Reset dropped during WR_A of a SWAP.
        do_cmd(2'b00, 3'd3, 3'd0, 16'h1234, r);
        do_cmd(2'b00, 3'd4, 3'd0, 16'hABCD, r);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dst = 3'd4; cmd_src = 3'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_wr_a_w_en", w_en, 1);
        check("abort_wr_a_addr", w_addr, 3);
        rst_n = 1'b0;
        #1;
        check("abort_w_en_drop", w_en, 0);
        check("abort_ready", cmd_ready, 0);
        check("abort_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rsp = 16'h0;
        check_regs("abort_regs");
        @(negedge clk);
        check("abort_no_resume", w_en, 0);
        check("abort_idle_ready", cmd_ready, 1);
        check("abort_rsp_clr", rsp_data, 0);
        do_cmd(2'b11, 3'd0, 3'd4, 16'h0, r);
        check("abort_R4", r, 16'hABCD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
